// File: rtl/i2c_target_regport_if.sv
// I2C target register-port bundle: pin-side lines plus the register-file side.
//   scl_in, sda_in : raw pin levels seen by the target
//   sda_oe         : 1 = pull SDA low, 0 = release (open-drain)
//   reg_addr       : current register pointer
//   reg_wdata      : write data, valid while reg_wr = 1
//   reg_wr         : one-clk write strobe
//   reg_rdata      : read data for reg_addr, combinational from reg_addr
//   busy           : target addressed and transfer in progress
interface i2c_target_regport_if;
   logic       scl_in;
   logic       sda_in;
   logic       sda_oe;
   logic [7:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_wr;
   logic [7:0] reg_rdata;
   logic       busy;

   // Target side (the i2c_target_regport block)
   modport slave (
      input  scl_in,
      input  sda_in,
      input  reg_rdata,
      output sda_oe,
      output reg_addr,
      output reg_wdata,
      output reg_wr,
      output busy
   );

   // Environment side (pads + register file)
   modport master (
      output scl_in,
      output sda_in,
      output reg_rdata,
      input  sda_oe,
      input  reg_addr,
      input  reg_wdata,
      input  reg_wr,
      input  busy
   );
endinterface

// File: rtl/i2c_target_regport.sv
// I2C target responder exposing a byte-addressed register space.
// Oversamples SCL/SDA on clk, decodes START/STOP/repeated START, ACKs DEV_ADDR,
// supports pointer write, data write and data read with auto-incrementing pointer.
// No clock stretching; SDA is only ever pulled low while SCL is low, or held
// low through SCL high for an ACK bit or a read-data 0 bit.
// Ports:
//   clk   : system clock, >= 16x SCL rate
//   rst_n : asynchronous active-low reset
//   bus   : i2c_target_regport_if.slave (pins + register-file handshake)
module i2c_target_regport #(
   parameter logic [6:0] DEV_ADDR = 7'h48
) (
   input  logic                         clk,
   input  logic                         rst_n,
   i2c_target_regport_if.slave          bus
);

   localparam int unsigned DW  = 8;
   localparam int unsigned BCW = 4;

   localparam logic [3:0] ST_IDLE      = 4'd0;
   localparam logic [3:0] ST_ADDR      = 4'd1;
   localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
   localparam logic [3:0] ST_WPTR      = 4'd3;
   localparam logic [3:0] ST_WPTR_ACK  = 4'd4;
   localparam logic [3:0] ST_WDATA     = 4'd5;
   localparam logic [3:0] ST_WDATA_ACK = 4'd6;
   localparam logic [3:0] ST_RDATA     = 4'd7;
   localparam logic [3:0] ST_RACK      = 4'd8;
   localparam logic [3:0] ST_IGNORE    = 4'd9;

   localparam logic [BCW-1:0] BITS_PER_BYTE = BCW'(8);

   // Synchronizers plus one history stage per line; reset to idle-bus level
   // so reset release never looks like an edge on a quiet bus.
   logic scl_s1, scl_s2, scl_h;
   logic sda_s1, sda_s2, sda_h;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_s1 <= 1'b1;
         scl_s2 <= 1'b1;
         scl_h  <= 1'b1;
         sda_s1 <= 1'b1;
         sda_s2 <= 1'b1;
         sda_h  <= 1'b1;
      end else begin
         scl_s1 <= bus.scl_in;
         scl_s2 <= scl_s1;
         scl_h  <= scl_s2;
         sda_s1 <= bus.sda_in;
         sda_s2 <= sda_s1;
         sda_h  <= sda_s2;
      end
   end

   // Bus events decoded from the synchronized lines
   logic scl_rise_c, scl_fall_c, start_c, stop_c;

   always_comb begin
      scl_rise_c = scl_s2 & ~scl_h;
      scl_fall_c = ~scl_s2 & scl_h;
      start_c    = scl_s2 & scl_h & ~sda_s2 & sda_h;
      stop_c     = scl_s2 & scl_h & sda_s2 & ~sda_h;
   end

   logic [3:0]     state,     state_d;
   logic [BCW-1:0] bit_cnt,   bit_cnt_d;
   logic [DW-1:0]  rx,        rx_d;
   logic [DW-1:0]  tx,        tx_d;
   logic           rw,        rw_d;
   logic           mack,      mack_d;
   logic           sda_oe,    sda_oe_d;
   logic           busy,      busy_d;
   logic [DW-1:0]  reg_addr,  reg_addr_d;
   logic [DW-1:0]  reg_wdata, reg_wdata_d;
   logic           reg_wr,    reg_wr_d;

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         rx        <= '0;
         tx        <= '0;
         rw        <= 1'b0;
         mack      <= 1'b0;
         sda_oe    <= 1'b0;
         busy      <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         reg_wr    <= 1'b0;
      end else begin
         state     <= state_d;
         bit_cnt   <= bit_cnt_d;
         rx        <= rx_d;
         tx        <= tx_d;
         rw        <= rw_d;
         mack      <= mack_d;
         sda_oe    <= sda_oe_d;
         busy      <= busy_d;
         reg_addr  <= reg_addr_d;
         reg_wdata <= reg_wdata_d;
         reg_wr    <= reg_wr_d;
      end
   end

   // Next-state and output logic. STOP beats START beats SCL edges.
   always_comb begin
      state_d     = state;
      bit_cnt_d   = bit_cnt;
      rx_d        = rx;
      tx_d        = tx;
      rw_d        = rw;
      mack_d      = mack;
      sda_oe_d    = sda_oe;
      busy_d      = busy;
      reg_addr_d  = reg_addr;
      reg_wdata_d = reg_wdata;
      reg_wr_d    = 1'b0;

      // Pointer advances the clk after the write strobe so reg_addr is
      // stable for the whole strobe.
      if (reg_wr) begin
         reg_addr_d = reg_addr + DW'(1);
      end

      if (stop_c) begin
         state_d   = ST_IDLE;
         bit_cnt_d = '0;
         sda_oe_d  = 1'b0;
         busy_d    = 1'b0;
      end else if (start_c) begin
         // Partial bytes are dropped; pointer is kept across repeated START.
         state_d   = ST_ADDR;
         bit_cnt_d = '0;
         sda_oe_d  = 1'b0;
         busy_d    = 1'b0;
      end else if (scl_rise_c) begin
         case (state)
            ST_ADDR, ST_WPTR, ST_WDATA, ST_RDATA: begin
               rx_d = {rx[DW-2:0], sda_s2};
               if (bit_cnt != BITS_PER_BYTE) begin
                  bit_cnt_d = bit_cnt + BCW'(1);
               end
            end
            ST_RACK: begin
               // Controller NACK ends the read right away.
               mack_d = ~sda_s2;
               if (sda_s2) begin
                  state_d = ST_IGNORE;
                  busy_d  = 1'b0;
               end
            end
            default: ;
         endcase
      end else if (scl_fall_c) begin
         case (state)
            ST_ADDR: begin
               if (bit_cnt == BITS_PER_BYTE) begin
                  bit_cnt_d = '0;
                  if (rx[DW-1:1] == DEV_ADDR) begin
                     sda_oe_d = 1'b1;
                     rw_d     = rx[0];
                     state_d  = ST_ADDR_ACK;
                  end else begin
                     state_d  = ST_IGNORE;
                  end
               end
            end
            ST_ADDR_ACK: begin
               busy_d    = 1'b1;
               bit_cnt_d = '0;
               if (rw) begin
                  tx_d     = bus.reg_rdata;
                  sda_oe_d = ~bus.reg_rdata[DW-1];
                  state_d  = ST_RDATA;
               end else begin
                  sda_oe_d = 1'b0;
                  state_d  = ST_WPTR;
               end
            end
            ST_WPTR: begin
               if (bit_cnt == BITS_PER_BYTE) begin
                  reg_addr_d = rx;
                  sda_oe_d   = 1'b1;
                  bit_cnt_d  = '0;
                  state_d    = ST_WPTR_ACK;
               end
            end
            ST_WPTR_ACK, ST_WDATA_ACK: begin
               sda_oe_d  = 1'b0;
               bit_cnt_d = '0;
               state_d   = ST_WDATA;
            end
            ST_WDATA: begin
               if (bit_cnt == BITS_PER_BYTE) begin
                  reg_wdata_d = rx;
                  reg_wr_d    = 1'b1;
                  sda_oe_d    = 1'b1;
                  bit_cnt_d   = '0;
                  state_d     = ST_WDATA_ACK;
               end
            end
            ST_RDATA: begin
               if (bit_cnt == BITS_PER_BYTE) begin
                  sda_oe_d   = 1'b0;
                  bit_cnt_d  = '0;
                  reg_addr_d = reg_addr + DW'(1);
                  state_d    = ST_RACK;
               end else begin
                  // Next bit goes out during this low phase.
                  tx_d     = {tx[DW-2:0], 1'b0};
                  sda_oe_d = ~tx[DW-2];
               end
            end
            ST_RACK: begin
               if (mack) begin
                  tx_d      = bus.reg_rdata;
                  sda_oe_d  = ~bus.reg_rdata[DW-1];
                  bit_cnt_d = '0;
                  state_d   = ST_RDATA;
               end
            end
            default: begin
               sda_oe_d = 1'b0;
            end
         endcase
      end
   end

   assign bus.sda_oe    = sda_oe;
   assign bus.busy      = busy;
   assign bus.reg_addr  = reg_addr;
   assign bus.reg_wdata = reg_wdata;
   assign bus.reg_wr    = reg_wr;

endmodule

// File: tb/tb_i2c_target_regport.sv
// Directed bench for i2c_target_regport: bit-banged I2C controller on an
// open-drain SDA model, register file returning reg_addr ^ 8'h5A, and a
// write-strobe log compared against hand-computed expectations.
`timescale 1ns/1ps
module tb_i2c_target_regport;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic scl_m = 1'b1;
   logic sda_m = 1'b1;

   i2c_target_regport_if bus();

   assign bus.scl_in    = scl_m;
   assign bus.sda_in    = sda_m & ~bus.sda_oe;
   assign bus.reg_rdata = bus.reg_addr ^ 8'h5A;

   i2c_target_regport #(.DEV_ADDR(7'h48)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] wr_addr[$];
   logic [7:0] wr_data[$];
   logic       oe_seen   = 1'b0;
   logic       busy_seen = 1'b0;

   // Log write strobes and activity on the falling clk edge
   always @(negedge clk) begin
      if (bus.reg_wr) begin
         wr_addr.push_back(bus.reg_addr);
         wr_data.push_back(bus.reg_wdata);
      end
      if (bus.sda_oe) oe_seen = 1'b1;
      if (bus.busy)   busy_seen = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_wr(input string tag, input int idx, input logic [7:0] a, input logic [7:0] d);
      if (idx < wr_addr.size()) begin
         check({tag, "_addr"}, wr_addr[idx], a);
         check({tag, "_data"}, wr_data[idx], d);
      end else begin
         check({tag, "_present"}, wr_addr.size(), idx + 1);
      end
   endtask

   task automatic clr_log();
      wr_addr.delete();
      wr_data.delete();
   endtask

   // Controller primitives, one SCL quarter period = 100 ns (10 clk)
   task automatic m_start();
      sda_m = 1'b1; #100;
      scl_m = 1'b1; #100;
      sda_m = 1'b0; #100;
      scl_m = 1'b0; #100;
   endtask

   task automatic m_stop();
      sda_m = 1'b0; #100;
      scl_m = 1'b1; #100;
      sda_m = 1'b1; #100;
   endtask

   task automatic m_bit(input logic b, output logic r);
      sda_m = b;    #100;
      scl_m = 1'b1; #100;
      r = bus.sda_in; #100;
      scl_m = 1'b0; #100;
   endtask

   task automatic m_wbyte(input logic [7:0] d, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) m_bit(d[i], r);
      m_bit(1'b1, r);
      ack = ~r;
   endtask

   task automatic m_rbyte(input logic nack, output logic [7:0] d);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         m_bit(1'b1, r);
         d[i] = r;
      end
      m_bit(nack, r);
   endtask

   initial begin
      logic       ack;
      logic       r;
      logic [7:0] d;
      logic [7:0] addr90;
      int         acks;

      // Reset values
      #50;
      check("rst_sda_oe",    bus.sda_oe,    1'b0);
      check("rst_reg_addr",  bus.reg_addr,  8'h00);
      check("rst_reg_wdata", bus.reg_wdata, 8'h00);
      check("rst_reg_wr",    bus.reg_wr,    1'b0);
      check("rst_busy",      bus.busy,      1'b0);
      rst_n = 1'b1;
      #200;

      // Single write
      clr_log();
      m_start();
      m_wbyte(8'h90, ack); check("t1_ack_addr", ack, 1'b1);
      check("t1_busy_on", bus.busy, 1'b1);
      m_wbyte(8'h10, ack); check("t1_ack_ptr", ack, 1'b1);
      m_wbyte(8'hA5, ack); check("t1_ack_data", ack, 1'b1);
      check("t1_busy_pre_stop", bus.busy, 1'b1);
      m_stop(); #200;
      check("t1_busy_off", bus.busy, 1'b0);
      check("t1_wr_count", wr_addr.size(), 1);
      chk_wr("t1_wr0", 0, 8'h10, 8'hA5);
      check("t1_reg_addr", bus.reg_addr, 8'h11);

      // Burst write across pointer wrap
      clr_log();
      acks = 0;
      m_start();
      m_wbyte(8'h90, ack); acks += int'(ack);
      m_wbyte(8'hFE, ack); acks += int'(ack);
      m_wbyte(8'h01, ack); acks += int'(ack);
      m_wbyte(8'h02, ack); acks += int'(ack);
      m_wbyte(8'h03, ack); acks += int'(ack);
      m_stop(); #200;
      check("t2_acks", acks, 5);
      check("t2_wr_count", wr_addr.size(), 3);
      chk_wr("t2_wr0", 0, 8'hFE, 8'h01);
      chk_wr("t2_wr1", 1, 8'hFF, 8'h02);
      chk_wr("t2_wr2", 2, 8'h00, 8'h03);
      check("t2_reg_addr", bus.reg_addr, 8'h01);

      // Pointer write, repeated START, two-byte read
      clr_log();
      m_start();
      m_wbyte(8'h90, ack); check("t3_ack_addr_w", ack, 1'b1);
      m_wbyte(8'h20, ack); check("t3_ack_ptr", ack, 1'b1);
      m_start();
      m_wbyte(8'h91, ack); check("t3_ack_addr_r", ack, 1'b1);
      m_rbyte(1'b0, d);    check("t3_rd0", d, 8'h7A);
      check("t3_busy_mid", bus.busy, 1'b1);
      m_rbyte(1'b1, d);    check("t3_rd1", d, 8'h7B);
      check("t3_busy_nack", bus.busy, 1'b0);
      m_stop(); #200;
      check("t3_wr_count", wr_addr.size(), 0);
      check("t3_reg_addr", bus.reg_addr, 8'h22);

      // Foreign address is ignored
      clr_log();
      oe_seen   = 1'b0;
      busy_seen = 1'b0;
      m_start();
      m_wbyte(8'hA0, ack); check("t4_nack_addr", ack, 1'b0);
      m_wbyte(8'h33, ack); check("t4_nack_data", ack, 1'b0);
      m_stop(); #200;
      check("t4_oe_seen",   oe_seen,   1'b0);
      check("t4_busy_seen", busy_seen, 1'b0);
      check("t4_wr_count",  wr_addr.size(), 0);
      check("t4_reg_addr",  bus.reg_addr, 8'h22);

      // STOP after a partial data byte, then a normal transaction
      clr_log();
      m_start();
      m_wbyte(8'h90, ack); check("t5_ack_addr", ack, 1'b1);
      m_wbyte(8'h40, ack); check("t5_ack_ptr", ack, 1'b1);
      m_bit(1'b1, r); m_bit(1'b0, r); m_bit(1'b1, r); m_bit(1'b1, r);
      m_stop(); #200;
      check("t5_partial_wr", wr_addr.size(), 0);
      check("t5_partial_ptr", bus.reg_addr, 8'h40);
      m_start();
      m_wbyte(8'h90, ack); check("t5b_ack_addr", ack, 1'b1);
      m_wbyte(8'h50, ack);
      m_wbyte(8'h3C, ack); check("t5b_ack_data", ack, 1'b1);
      m_stop(); #200;
      check("t5b_wr_count", wr_addr.size(), 1);
      chk_wr("t5b_wr0", 0, 8'h50, 8'h3C);
      check("t5b_reg_addr", bus.reg_addr, 8'h51);

      // Async reset in the address-ACK low phase
      clr_log();
      addr90 = 8'h90;
      m_start();
      for (int i = 7; i >= 0; i--) m_bit(addr90[i], r);
      check("t6_pre_oe", bus.sda_oe, 1'b1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_oe",    bus.sda_oe,    1'b0);
      check("t6_rst_addr",  bus.reg_addr,  8'h00);
      check("t6_rst_wdata", bus.reg_wdata, 8'h00);
      check("t6_rst_wr",    bus.reg_wr,    1'b0);
      check("t6_rst_busy",  bus.busy,      1'b0);
      #99;
      rst_n = 1'b1;
      #100;
      m_stop(); #200;
      m_start();
      m_wbyte(8'h90, ack); check("t6_ack_addr", ack, 1'b1);
      m_wbyte(8'h05, ack); check("t6_ack_ptr", ack, 1'b1);
      m_wbyte(8'h66, ack); check("t6_ack_data", ack, 1'b1);
      m_stop(); #200;
      check("t6_wr_count", wr_addr.size(), 1);
      chk_wr("t6_wr0", 0, 8'h05, 8'h66);
      check("t6_reg_addr", bus.reg_addr, 8'h06);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_target_regport.md
Name: i2c_target_regport

Overview:
- I2C target (slave) responder: the other end of our DAC-config I2C master; lets the FPGA present a byte-addressed register space to an external I2C controller.
- Oversamples SCL/SDA on clk, decodes START/STOP/repeated START, ACKs its own address, and supports write and read with an auto-incrementing register pointer.
- Sits between the open-drain pad logic (top level: sda = sda_oe ? 1'b0 : 1'bz; scl input only, no clock stretching) and a register file.

Parameters:
DEV_ADDR, 7'h48, 7-bit target address this block ACKs.

Ports:
clk  input  1  system clock, >= 16x SCL rate.
rst_n  input  1  reset, asynchronous, active-low.
scl_in  input  1  raw SCL pin level.
sda_in  input  1  raw SDA pin level.
sda_oe  output  1  1 = pull SDA low; 0 = release.
reg_addr  output  8  current register pointer.
reg_wdata  output  8  write data; valid while reg_wr = 1.
reg_wr  output  1  one-clk write strobe.
reg_rdata  input  8  read data for reg_addr; combinational from reg_addr, stable within 1 clk.
busy  output  1  1 from addressed-ACK until STOP, NACKed read, or next START.

Behaviour:
- Reset values: sda_oe=0, reg_addr=8'h00, reg_wdata=8'h00, reg_wr=0, busy=0, state=IDLE. Reset is async; sda_oe releases immediately, mid-transfer included.
- Input path: 2-FF synchronizer per line plus one history FF.
  - scl_rise / scl_fall = edge on synced SCL.
  - START = synced SDA 1->0 while SCL high.
  - STOP = synced SDA 0->1 while SCL high.
  - Pin-to-event latency is 3 clk.
- SCL rise samples a bit, MSB first. SCL fall updates sda_oe, which changes on the clk after scl_fall is detected.
- START, including repeated START, in any state: clear bit count, go to ADDR, release sda_oe. The pointer is kept.
- STOP in any state: go to IDLE, sda_oe=0, busy=0.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. On the 8th fall: if addr[7:1]==DEV_ADDR, drive sda_oe=1 and go to ADDR_ACK; otherwise go to IGNORE (sda_oe stays 0).
  - ADDR_ACK: on the next fall, release SDA and set busy=1.
    - R/W=0: go to WPTR.
    - R/W=1: load tx shift register with reg_rdata, drive its MSB (sda_oe = ~bit), go to RDATA.
  - WPTR: 8 bits -> reg_addr on the 8th fall; ACK (sda_oe=1 for one SCL low+high); then WDATA.
  - WDATA: 8 bits. On the 8th fall:
    - reg_wdata = byte, reg_wr = 1 for exactly 1 clk with reg_addr unchanged.
    - ACK is driven.
    - reg_addr increments on the clk after reg_wr.
    - Stay in WDATA for further bytes.
  - RDATA: shift out on each fall (sda_oe = ~bit). After the 8th bit's fall, release SDA, go to RACK, and increment reg_addr.
  - RACK: sample the master bit on rise.
    - 0 (ACK): on the next fall, load reg_rdata (new pointer) and go to RDATA.
    - 1 (NACK): go to IGNORE and set busy=0.
  - IGNORE: sda_oe=0; wait for START or STOP.
- Pointer arithmetic: 8-bit, wraps 8'hFF -> 8'h00. A write of only the pointer byte (then STOP or repeated START) sets the read pointer with no reg_wr.
- Partial byte at START/STOP: discard it, no reg_wr, no pointer change.
- sda_oe is never asserted while SCL is high except during an ACK bit or a read-data 0 bit held through the high phase. This guarantees the block never creates a false START/STOP.

Test Plan:
- Write [0x90, 0x10, 0xA5, STOP] (DEV_ADDR=0x48) -> ACK on all 3 bytes; one reg_wr with reg_addr=0x10, reg_wdata=0xA5; reg_addr=0x11 after; busy falls at STOP.
- Burst write [0x90, 0xFE, 0x01, 0x02, 0x03, STOP] -> reg_wr at 0xFE, 0xFF, 0x00 with data 01/02/03; reg_addr=0x01 at end.
- Write [0x90, 0x20], repeated START, [0x91], read 2 bytes (master ACK then NACK), STOP, with reg_rdata = reg_addr ^ 8'h5A -> SDA bytes 0x7A, 0x7B; no reg_wr; reg_addr=0x22.
- Address [0xA0, 0x33, STOP] -> sda_oe stays 0 throughout; no reg_wr; busy stays 0.
- STOP after 4 bits of a data byte -> no reg_wr, pointer unchanged; the next transaction works normally.
- rst_n low during an ADDR_ACK low phase -> sda_oe=0 within the same clk (async); all outputs at reset values; the next START is decoded.
